mips_watchdog_timer: RTL and testbench
======================================

// Module: mips_watchdog_timer
// PURPOSE
//  Watchdog timer that receives the wait-period write command decoded by the MIPS control unit.
//  Software arms it by writing a period; each later write reloads it (kick).
//  If no write arrives within the period, the block raises o_cpu_reset for a fixed number of cycles.
//  Sits beside the datapath: period comes from register-file read port 1, w_en from the control unit.
// PARAMETERS
//  WIDTH          32  width of the period and down-counter
//  RST_PULSE_LEN  4   cycles o_cpu_reset is held high per timeout (>=1)
//  TO_CNT_WIDTH   8   width of the saturating timeout counter
// PORTS
//  i_clk              in   1             system clock, rising edge
//  i_reset            in   1             asynchronous, active-high reset of this block
//  i_wait_period_w_en in   1             wait-period write strobe from control unit
//  i_wait_period      in   WIDTH         period value in cycles; 0 = disable
//  o_cpu_reset        out  1             registered reset request to the CPU core
//  o_active           out  1             1 when armed (COUNT or FIRE state)
//  o_counter          out  WIDTH         current down-counter value
//  o_timeout_count    out  TO_CNT_WIDTH  number of expirations since i_reset, saturating
// BEHAVIOUR
//  - Reset (async, i_reset=1): state=IDLE; period_reg, counter, pulse_cnt, o_timeout_count=0.
//    o_cpu_reset=0, o_active=0. Effect is immediate, including mid-FIRE.
//  - All outputs are registered. No combinational path runs from inputs to outputs.
//  - States:
//    - IDLE: disarmed, counter held at 0.
//    - COUNT: counting down.
//    - FIRE: reset pulse in progress.
//  - IDLE: w_en with period N>0 at edge k -> period_reg=N, counter=N, state=COUNT after edge k.
//    w_en with N=0 -> stays IDLE.
//  - COUNT, no w_en: counter decrements by 1 per edge.
//    At the edge where counter==1: state=FIRE, counter=0, o_cpu_reset=1, pulse_cnt=RST_PULSE_LEN-1.
//    o_timeout_count increments unless it is all-ones.
//    Net effect: arm/kick at edge k -> o_cpu_reset high after edge k+N.
//  - COUNT, w_en with N>0: period_reg=N, counter=N (kick). A write on the expiry edge wins; no FIRE.
//  - COUNT, w_en with N=0: state=IDLE, counter=0 (disarm).
//  - FIRE: o_cpu_reset stays 1 for exactly RST_PULSE_LEN cycles. pulse_cnt decrements each edge.
//    On the edge where pulse_cnt==0: o_cpu_reset=0, counter=period_reg, state=COUNT (auto re-arm).
//  - FIRE ignores w_en, because the CPU is held in reset.
//  - o_cpu_reset does not clear this block. Only i_reset clears period_reg and o_timeout_count.
//  - Counter arithmetic is unsigned WIDTH-bit. Counter never wraps: the 1->FIRE transition
//    pre-empts 0, and the counter is never decremented in IDLE or FIRE.
//  - o_active = (state != IDLE), registered with the state.
// STRUCTURE
//  - Shared mips defines include gets:
//    - state localparams WDT_IDLE=2'd0, WDT_COUNT=2'd1, WDT_FIRE=2'd2
//    - the wait-period opcode, already used by the control unit
//  - One sub-module: mips_wdt_pulse_gen (load/start, RST_PULSE_LEN down-counter, o_pulse, o_done).
//    It owns pulse_cnt and o_cpu_reset. The top holds the FSM, period_reg, counter and timeout counter.
// TESTING
//  1. Arm: w_en, period=5 at edge 0 -> o_active=1. o_counter 5,4,3,2,1.
//     o_cpu_reset=1 after edge 5 for 4 cycles, then o_counter=5 and COUNT resumes. o_timeout_count=1.
//  2. Kick: period=5. Rewrite 5 at edges 3, 6, 9 -> o_cpu_reset never rises. Same-edge-as-expiry write also suppresses.
//  3. Disarm: in COUNT, write period=0 -> IDLE, o_active=0, o_counter=0, no pulse ever.
//  4. FIRE ignores writes: w_en period=100 during pulse -> pulse still 4 cycles. Reload value = old period_reg.
//  5. Async reset mid-FIRE: assert i_reset between clock edges -> o_cpu_reset=0, o_active=0, o_timeout_count=0 immediately.
//  6. Saturation: TO_CNT_WIDTH=2, period=1, run 6 timeouts -> o_timeout_count stops at 3.

Source files
------------

// File: rtl/mips_watchdog_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_watchdog_timer_pkg
// Description : Shared watchdog definitions: FSM state encoding and the
//               wait-period opcode decoded by the MIPS control unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_watchdog_timer_pkg;

    typedef logic [1:0] wdt_state_t;

    localparam wdt_state_t WDT_IDLE  = 2'd0;
    localparam wdt_state_t WDT_COUNT = 2'd1;
    localparam wdt_state_t WDT_FIRE  = 2'd2;

    // Opcode the control unit decodes into i_wait_period_w_en.
    localparam logic [5:0] OP_WAIT_PERIOD = 6'h3b;

endpackage
`default_nettype wire

// File: rtl/mips_wdt_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : mips_wdt_pulse_gen
// Description : Emits a registered pulse exactly RST_PULSE_LEN cycles long
//               after a start strobe; o_done flags the pulse's final cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_wdt_pulse_gen #(
    parameter int RST_PULSE_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    output logic o_pulse,
    output logic o_done
);

    localparam int c_cnt_w = (RST_PULSE_LEN > 1) ? $clog2(RST_PULSE_LEN) : 1;

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_pulse;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_pulse <= 1'b0;
        end else if (i_start) begin
            // Loading LEN-1 here and ending on zero gives LEN high cycles.
            r_cnt   <= c_cnt_w'(RST_PULSE_LEN - 1);
            r_pulse <= 1'b1;
        end else if (r_pulse) begin
            if (r_cnt == '0) begin
                r_pulse <= 1'b0;
            end else begin
                r_cnt <= r_cnt - c_cnt_w'(1);
            end
        end
    end

    assign o_pulse = r_pulse;
    assign o_done  = r_pulse && (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/mips_watchdog_timer.sv
`default_nettype none
// ============================================================================
// Module      : mips_watchdog_timer
// Description : Software-kicked watchdog; raises o_cpu_reset for a fixed
//               number of cycles when no period write arrives in time.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_watchdog_timer
    import mips_watchdog_timer_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int RST_PULSE_LEN = 4,
    parameter int TO_CNT_WIDTH  = 8
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_wait_period_w_en,
    input  logic [WIDTH-1:0]        i_wait_period,
    output logic                    o_cpu_reset,
    output logic                    o_active,
    output logic [WIDTH-1:0]        o_counter,
    output logic [TO_CNT_WIDTH-1:0] o_timeout_count
);

    wdt_state_t              r_state;
    logic [WIDTH-1:0]        r_period;
    logic [WIDTH-1:0]        r_counter;
    logic [TO_CNT_WIDTH-1:0] r_timeout;

    logic w_expire;
    logic w_pulse;
    logic w_pulse_done;

    // A write on the expiry edge is a kick, so it suppresses the timeout.
    assign w_expire = (r_state == WDT_COUNT) && !i_wait_period_w_en
                      && (r_counter == WIDTH'(1));

    mips_wdt_pulse_gen #(
        .RST_PULSE_LEN(RST_PULSE_LEN)
    ) u_pulse_gen (
        .clk    (i_clk),
        .rst    (i_reset),
        .i_start(w_expire),
        .o_pulse(w_pulse),
        .o_done (w_pulse_done)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= WDT_IDLE;
            r_period  <= '0;
            r_counter <= '0;
            r_timeout <= '0;
        end else begin
            case (r_state)
                WDT_IDLE: begin
                    if (i_wait_period_w_en && (i_wait_period != '0)) begin
                        r_period  <= i_wait_period;
                        r_counter <= i_wait_period;
                        r_state   <= WDT_COUNT;
                    end
                end
                WDT_COUNT: begin
                    if (i_wait_period_w_en) begin
                        if (i_wait_period != '0) begin
                            r_period  <= i_wait_period;
                            r_counter <= i_wait_period;
                        end else begin
                            r_counter <= '0;
                            r_state   <= WDT_IDLE;
                        end
                    end else if (w_expire) begin
                        r_counter <= '0;
                        r_state   <= WDT_FIRE;
                        if (r_timeout != '1) begin
                            r_timeout <= r_timeout + TO_CNT_WIDTH'(1);
                        end
                    end else begin
                        r_counter <= r_counter - WIDTH'(1);
                    end
                end
                WDT_FIRE: begin
                    // Writes are ignored here: the CPU is held in reset.
                    if (w_pulse_done) begin
                        r_counter <= r_period;
                        r_state   <= WDT_COUNT;
                    end
                end
                default: begin
                    r_counter <= '0;
                    r_state   <= WDT_IDLE;
                end
            endcase
        end
    end

    assign o_cpu_reset     = w_pulse;
    assign o_active        = (r_state != WDT_IDLE);
    assign o_counter       = r_counter;
    assign o_timeout_count = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_mips_watchdog_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_watchdog_timer
// Description : Self-checking bench for mips_watchdog_timer using a
//               deadline-based reference model plus literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_watchdog_timer;

    localparam int W   = 32;
    localparam int LEN = 4;
    localparam int TW  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          w_en;
    logic [W-1:0]  period;
    logic          cpu_reset;
    logic          active;
    logic [W-1:0]  counter;
    logic [TW-1:0] timeout_count;

    logic          s_w_en;
    logic [7:0]    s_period;
    logic          s_cpu_reset;
    logic          s_active;
    logic [7:0]    s_counter;
    logic [1:0]    s_timeout_count;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    mips_watchdog_timer #(.WIDTH(W), .RST_PULSE_LEN(LEN), .TO_CNT_WIDTH(TW)) u_dut (
        .i_clk             (clk),
        .i_reset           (rst),
        .i_wait_period_w_en(w_en),
        .i_wait_period     (period),
        .o_cpu_reset       (cpu_reset),
        .o_active          (active),
        .o_counter         (counter),
        .o_timeout_count   (timeout_count)
    );

    mips_watchdog_timer #(.WIDTH(8), .RST_PULSE_LEN(4), .TO_CNT_WIDTH(2)) u_sat (
        .i_clk             (clk),
        .i_reset           (rst),
        .i_wait_period_w_en(s_w_en),
        .i_wait_period     (s_period),
        .o_cpu_reset       (s_cpu_reset),
        .o_active          (s_active),
        .o_counter         (s_counter),
        .o_timeout_count   (s_timeout_count)
    );

    // Model: mode 0 idle, 1 counting toward an absolute deadline edge, 2 firing
    // until an absolute end edge. The counter is the distance to the deadline.
    int     m_mode;
    longint m_n, m_deadline, m_fire_end, m_period;
    int     m_to;

    task automatic model_reset();
        m_mode = 0; m_period = 0; m_to = 0; m_deadline = 0; m_fire_end = 0;
    endtask

    task automatic model_edge(input logic w, input longint p);
        m_n++;
        case (m_mode)
            0: if (w && p != 0) begin
                m_mode = 1; m_period = p; m_deadline = m_n + p;
            end
            1: if (w) begin
                if (p != 0) begin
                    m_period = p; m_deadline = m_n + p;
                end else begin
                    m_mode = 0;
                end
            end else if (m_n == m_deadline) begin
                m_mode = 2; m_fire_end = m_n + LEN;
                if (m_to < (1 << TW) - 1) m_to++;
            end
            default: if (m_n == m_fire_end) begin
                m_mode = 1; m_deadline = m_n + m_period;
            end
        endcase
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("model_cpu_reset", cpu_reset, m_mode == 2);
        chk("model_active", active, m_mode != 0);
        chk("model_counter", counter, (m_mode == 1) ? (m_deadline - m_n) : 64'd0);
        chk("model_timeout", timeout_count, m_to);
    endtask

    task automatic step(input logic w, input logic [W-1:0] p);
        @(negedge clk);
        w_en = w; period = p;
        @(posedge clk);
        model_edge(w, p);
        #1 compare_model();
    endtask

    initial begin
        m_n = 0;
        rst = 1'b1; w_en = 1'b0; period = '0; s_w_en = 1'b0; s_period = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_cpu_reset", cpu_reset, 0);
        chk("reset_active", active, 0);
        chk("reset_counter", counter, 0);
        chk("reset_timeout", timeout_count, 0);
        @(negedge clk) rst = 1'b0;

        // Arm with 5: count 5..1, four-cycle pulse, then re-arm at 5.
        step(1'b1, 5);
        chk("arm_active", active, 1);
        chk("arm_counter", counter, 5);
        for (int i = 4; i >= 1; i--) begin
            step(1'b0, 0);
            chk("arm_countdown", counter, i);
        end
        for (int i = 0; i < LEN; i++) begin
            step(1'b0, 0);
            chk("fire_pulse", cpu_reset, 1);
            chk("fire_counter", counter, 0);
        end
        chk("fire_timeout", timeout_count, 1);
        step(1'b0, 0);
        chk("rearm_cpu_reset", cpu_reset, 0);
        chk("rearm_counter", counter, 5);

        // Kick every third edge, then kick exactly on the expiry edge.
        step(1'b1, 5);
        for (int i = 1; i <= 12; i++) begin
            step(i % 3 == 0, 5);
            chk("kick_no_pulse", cpu_reset, 0);
        end
        repeat (4) step(1'b0, 0);
        step(1'b1, 5);
        chk("expiry_kick_no_pulse", cpu_reset, 0);
        chk("expiry_kick_counter", counter, 5);

        // Disarm.
        step(1'b1, 0);
        chk("disarm_active", active, 0);
        chk("disarm_counter", counter, 0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 0);
            chk("disarm_no_pulse", cpu_reset, 0);
        end

        // Writes during FIRE are ignored; reload uses the old period.
        step(1'b1, 3);
        step(1'b0, 0);
        step(1'b0, 0);
        step(1'b0, 0);
        chk("ign_fire_start", cpu_reset, 1);
        for (int i = 0; i < LEN - 1; i++) begin
            step(1'b1, 100);
            chk("ign_fire_hold", cpu_reset, 1);
        end
        step(1'b1, 100);
        chk("ign_fire_end", cpu_reset, 0);
        chk("ign_fire_reload", counter, 3);
        step(1'b0, 0);
        chk("ign_fire_next", counter, 2);

        // Randomized traffic with small periods so expiries are frequent.
        for (int i = 0; i < 3000; i++) begin
            logic            w;
            logic [W-1:0]    p;
            w = ($urandom_range(0, 5) == 0);
            p = ($urandom_range(0, 9) == 0) ? W'(0) : W'($urandom_range(1, 9));
            step(w, p);
        end

        // Async reset in the middle of a pulse.
        step(1'b1, 2);
        step(1'b0, 0);
        step(1'b0, 0);
        chk("async_pre_pulse", cpu_reset, 1);
        step(1'b0, 0);
        #2 rst = 1'b1;
        #1;
        chk("async_cpu_reset", cpu_reset, 0);
        chk("async_active", active, 0);
        chk("async_timeout", timeout_count, 0);
        chk("async_counter", counter, 0);
        model_reset();
        @(negedge clk) rst = 1'b0;

        // Saturation on a 2-bit timeout counter with period 1.
        s_w_en = 1'b1; s_period = 8'd1;
        step(1'b0, 0);
        s_w_en = 1'b0; s_period = 8'd0;
        step(1'b0, 0);
        chk("sat_first_pulse", s_cpu_reset, 1);
        chk("sat_first_count", s_timeout_count, 1);
        repeat (4) step(1'b0, 0);
        step(1'b0, 0);
        chk("sat_second_count", s_timeout_count, 2);
        repeat (25) step(1'b0, 0);
        chk("sat_held", s_timeout_count, 3);
        chk("sat_still_active", s_active, 1);
        repeat (10) step(1'b0, 0);
        chk("sat_held_late", s_timeout_count, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
